// File: rtl/ifmaps_row_sequencer_pkg.sv
// Shared constants, state encoding and sizing helper for the ifmaps row sequencer.
package ifmaps_row_sequencer_pkg;

  localparam int KH = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  // Bits needed to index 0..value-1, never less than 1.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ifmaps_row_sequencer_line_buffer.sv
// Four-row line buffer: shift-on-write per column, combinational column read (pre-shift).
module ifmaps_line_buffer
  import ifmaps_row_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int IMG_W      = 28,
  parameter int COL_W      = clogb2(IMG_W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [COL_W-1:0]      col,
  input  logic [DATA_WIDTH-1:0] pix_in,
  output logic [DATA_WIDTH-1:0] col0,
  output logic [DATA_WIDTH-1:0] col1,
  output logic [DATA_WIDTH-1:0] col2,
  output logic [DATA_WIDTH-1:0] col3
);

  logic [DATA_WIDTH-1:0] lb0 [IMG_W];
  logic [DATA_WIDTH-1:0] lb1 [IMG_W];
  logic [DATA_WIDTH-1:0] lb2 [IMG_W];
  logic [DATA_WIDTH-1:0] lb3 [IMG_W];

  assign col0 = lb0[col];
  assign col1 = lb1[col];
  assign col2 = lb2[col];
  assign col3 = lb3[col];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
        lb2[i] <= '0;
        lb3[i] <= '0;
      end
    end else if (wr_en) begin
      lb0[col] <= lb1[col];
      lb1[col] <= lb2[col];
      lb2[col] <= lb3[col];
      lb3[col] <= pix_in;
    end
  end

endmodule

// File: rtl/ifmaps_row_sequencer.sv
// Row-major pixel stream to 5-deep vertical column words for the MAC ifmaps FIFO.
// Optional stall counter port enabled by defining IFMAPS_SEQ_STALL_CNT_EN.
module ifmaps_row_sequencer
  import ifmaps_row_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] ifmaps_fifo_row0_in,
  output logic [DATA_WIDTH-1:0] ifmaps_fifo_row1_in,
  output logic [DATA_WIDTH-1:0] ifmaps_fifo_row2_in,
  output logic [DATA_WIDTH-1:0] ifmaps_fifo_row3_in,
  output logic [DATA_WIDTH-1:0] ifmaps_fifo_row4_in,
  output logic                  ifmaps_input_valid,
  input  logic                  fifo_full,
  output logic                  busy,
  output logic                  frame_done
`ifdef IFMAPS_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  // state  | meaning
  // IDLE   | waiting for start
  // FILL   | rows 0..3 go into the line buffer only
  // STREAM | every accepted pixel also loads a column word
  // DRAIN  | last pixel taken, waiting for the output register to empty

  localparam int COL_W = clogb2(IMG_W);
  localparam int ROW_W = clogb2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_FILL_LAST = ROW_W'(KH - 2);

  logic [1:0]            state;
  logic [COL_W-1:0]      col_cnt;
  logic [ROW_W-1:0]      row_cnt;
  logic                  accept;
  logic                  consume;
  logic                  load;
  logic                  row_end;
  logic                  start_go;
  logic [DATA_WIDTH-1:0] lb_col0, lb_col1, lb_col2, lb_col3;

  always_comb begin
    pix_ready = 1'b0;
    case (state)
      ST_FILL:   pix_ready = 1'b1;
      ST_STREAM: pix_ready = ~ifmaps_input_valid | ~fifo_full;
      default:   pix_ready = 1'b0;
    endcase
  end

  assign accept   = pix_valid & pix_ready;
  assign consume  = ifmaps_input_valid & ~fifo_full;
  assign load     = accept & (state == ST_STREAM);
  assign row_end  = (col_cnt == COL_LAST);
  assign start_go = start & (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  ifmaps_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_W      (IMG_W),
    .COL_W      (COL_W)
  ) u_line_buffer (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (accept),
    .col    (col_cnt),
    .pix_in (pix_in),
    .col0   (lb_col0),
    .col1   (lb_col1),
    .col2   (lb_col2),
    .col3   (lb_col3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      col_cnt    <= '0;
      row_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_FILL;
            col_cnt <= '0;
            row_cnt <= '0;
          end
        end
        ST_FILL: begin
          if (accept && row_end && (row_cnt == ROW_FILL_LAST)) state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (accept && row_end && (row_cnt == ROW_LAST)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!ifmaps_input_valid || consume) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (accept) begin
        if (row_end) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

  // Load wins over consume so a same-edge hand-off keeps valid high with new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifmaps_input_valid  <= 1'b0;
      ifmaps_fifo_row0_in <= '0;
      ifmaps_fifo_row1_in <= '0;
      ifmaps_fifo_row2_in <= '0;
      ifmaps_fifo_row3_in <= '0;
      ifmaps_fifo_row4_in <= '0;
    end else if (load) begin
      ifmaps_input_valid  <= 1'b1;
      ifmaps_fifo_row0_in <= lb_col0;
      ifmaps_fifo_row1_in <= lb_col1;
      ifmaps_fifo_row2_in <= lb_col2;
      ifmaps_fifo_row3_in <= lb_col3;
      ifmaps_fifo_row4_in <= pix_in;
    end else if (consume) begin
      ifmaps_input_valid <= 1'b0;
    end
  end

`ifdef IFMAPS_SEQ_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (start_go) begin
      stall_cnt <= '0;
    end else if (ifmaps_input_valid && fifo_full && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifmaps_row_sequencer.sv
// Directed bench for ifmaps_row_sequencer: 4x6 frame of 8-bit pixels (row*16+col).
module tb_ifmaps_row_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [7:0] row0, row1, row2, row3, row4;
  logic       ifmaps_input_valid;
  logic       fifo_full = 1'b0;
  logic       busy;
  logic       frame_done;
`ifdef IFMAPS_SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int pass_cnt = 0;
  int total = 0;
  int cyc_cnt = 0;
  int done_cnt = 0;
  int first_valid_cyc = -1;
  int accept_cyc = -1;
  logic [39:0] words[$];
  logic [39:0] word;

  assign word = {row0, row1, row2, row3, row4};

  ifmaps_row_sequencer #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(6)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .pix_in              (pix_in),
    .pix_valid           (pix_valid),
    .pix_ready           (pix_ready),
    .ifmaps_fifo_row0_in (row0),
    .ifmaps_fifo_row1_in (row1),
    .ifmaps_fifo_row2_in (row2),
    .ifmaps_fifo_row3_in (row3),
    .ifmaps_fifo_row4_in (row4),
    .ifmaps_input_valid  (ifmaps_input_valid),
    .fifo_full           (fifo_full),
    .busy                (busy),
    .frame_done          (frame_done)
`ifdef IFMAPS_SEQ_STALL_CNT_EN
    ,
    .stall_cnt           (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Words are recorded on the negedge before the edge that consumes them.
  always @(negedge clk) begin
    if (rst_n && ifmaps_input_valid && !fifo_full) words.push_back(word);
    if (rst_n && ifmaps_input_valid && first_valid_cyc < 0) first_valid_cyc <= cyc_cnt;
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [39:0] exp_word(input int k);
    int r, c;
    logic [39:0] w;
    r = 4 + k / 4;
    c = k % 4;
    w = '0;
    for (int i = 0; i < 5; i++) w = {w[31:0], 8'((r - 4 + i) * 16 + c)};
    return w;
  endfunction

  task automatic clear_obs();
    words.delete();
    done_cnt = 0;
    first_valid_cyc = -1;
    accept_cyc = -1;
  endtask

  task automatic drive_frame(input bit do_start, input bit toggle, input bit start_mid,
                             input int abort_words);
    int p;
    int cyc;
    bit acc;
    p = 0;
    cyc = 0;
    if (do_start) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    while (p < 24 && cyc < 1000) begin
      if (abort_words > 0 && words.size() >= abort_words && ifmaps_input_valid) break;
      pix_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      pix_in    = 8'((p / 4) * 16 + p % 4);
      start     = start_mid && (p == 5);
      @(negedge clk);
      acc = pix_valid && pix_ready;
      if (acc && p == 16) accept_cyc = cyc_cnt;
      @(posedge clk); #1;
      if (acc) p++;
      cyc++;
    end
    pix_valid = 1'b0;
    start = 1'b0;
    total++;
    if (cyc >= 1000) $display("FAIL drive_timeout: pixels accepted %0d, required 24", p);
    else pass_cnt++;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (word !== 40'h0 || ifmaps_input_valid !== 1'b0)
      $display("FAIL reset_outputs: word=%h valid=%b, required 0/0", word, ifmaps_input_valid);
    else pass_cnt++;
    total++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || pix_ready !== 1'b0)
      $display("FAIL reset_ctrl: busy=%b done=%b ready=%b, required 000", busy, frame_done, pix_ready);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    // Pixels offered in IDLE must be ignored.
    @(posedge clk); #1;
    pix_valid = 1'b1;
    pix_in = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (pix_ready !== 1'b0 || busy !== 1'b0)
        $display("FAIL idle_ignore: ready=%b busy=%b, required 0/0", pix_ready, busy);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic test_basic();
    clear_obs();
    drive_frame(1'b1, 1'b0, 1'b0, 0);
    wait_done();
    total++;
    if (first_valid_cyc !== accept_cyc + 1)
      $display("FAIL basic_latency: valid cycle %0d, required %0d", first_valid_cyc, accept_cyc + 1);
    else pass_cnt++;
    total++;
    if (words.size() !== 8) $display("FAIL basic_count: got %0d words, required 8", words.size());
    else pass_cnt++;
    for (int k = 0; k < 8 && k < words.size(); k++) begin
      total++;
      if (words[k] !== exp_word(k))
        $display("FAIL basic_word%0d: got %h, required %h", k, words[k], exp_word(k));
      else pass_cnt++;
    end
    total++;
    if (done_cnt !== 1 || busy !== 1'b0)
      $display("FAIL basic_done: pulses %0d busy %b, required 1/0", done_cnt, busy);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    clear_obs();
    fork
      drive_frame(1'b1, 1'b0, 1'b0, 0);
      begin
        int n;
        n = 0;
        while (!(ifmaps_input_valid && words.size() == 2) && n < 500) begin
          @(posedge clk); #1;
          n++;
        end
        fifo_full = 1'b1;
        repeat (5) begin
          @(negedge clk);
          total++;
          if (word !== exp_word(2) || ifmaps_input_valid !== 1'b1)
            $display("FAIL stall_hold: word=%h valid=%b, required %h/1", word, ifmaps_input_valid, exp_word(2));
          else pass_cnt++;
          total++;
          if (pix_ready !== 1'b0) $display("FAIL stall_ready: ready=%b, required 0", pix_ready);
          else pass_cnt++;
          @(posedge clk);
        end
        #1 fifo_full = 1'b0;
      end
    join
    wait_done();
    total++;
    if (words.size() !== 8) $display("FAIL stall_count: got %0d words, required 8", words.size());
    else pass_cnt++;
    for (int k = 0; k < 8 && k < words.size(); k++) begin
      total++;
      if (words[k] !== exp_word(k))
        $display("FAIL stall_word%0d: got %h, required %h", k, words[k], exp_word(k));
      else pass_cnt++;
    end
    total++;
    if (done_cnt !== 1) $display("FAIL stall_done: pulses %0d, required 1", done_cnt);
    else pass_cnt++;
`ifdef IFMAPS_SEQ_STALL_CNT_EN
    total++;
    if (stall_cnt !== 32'd5) $display("FAIL stall_cnt_value: got %0d, required 5", stall_cnt);
    else pass_cnt++;
    clear_obs();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    total++;
    if (stall_cnt !== 32'd0) $display("FAIL stall_cnt_clear: got %0d, required 0", stall_cnt);
    else pass_cnt++;
    drive_frame(1'b0, 1'b0, 1'b0, 0);
    wait_done();
    total++;
    if (words.size() !== 8 || done_cnt !== 1)
      $display("FAIL stall_cnt_frame: words %0d pulses %0d, required 8/1", words.size(), done_cnt);
    else pass_cnt++;
`endif
  endtask

  task automatic test_toggle();
    clear_obs();
    drive_frame(1'b1, 1'b1, 1'b0, 0);
    wait_done();
    total++;
    if (words.size() !== 8) $display("FAIL toggle_count: got %0d words, required 8", words.size());
    else pass_cnt++;
    for (int k = 0; k < 8 && k < words.size(); k++) begin
      total++;
      if (words[k] !== exp_word(k))
        $display("FAIL toggle_word%0d: got %h, required %h", k, words[k], exp_word(k));
      else pass_cnt++;
    end
    total++;
    if (done_cnt !== 1) $display("FAIL toggle_done: pulses %0d, required 1", done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_stream();
    clear_obs();
    drive_frame(1'b1, 1'b0, 1'b0, 4);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (word !== 40'h0 || ifmaps_input_valid !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b0)
      $display("FAIL midreset_async: word=%h valid=%b busy=%b ready=%b, required all 0",
               word, ifmaps_input_valid, busy, pix_ready);
    else pass_cnt++;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (done_cnt !== 0 || busy !== 1'b0)
      $display("FAIL midreset_nodone: pulses %0d busy %b, required 0/0", done_cnt, busy);
    else pass_cnt++;
    clear_obs();
    drive_frame(1'b1, 1'b0, 1'b0, 0);
    wait_done();
    total++;
    if (words.size() !== 8) $display("FAIL midreset_count: got %0d words, required 8", words.size());
    else pass_cnt++;
    for (int k = 0; k < 8 && k < words.size(); k++) begin
      total++;
      if (words[k] !== exp_word(k))
        $display("FAIL midreset_word%0d: got %h, required %h", k, words[k], exp_word(k));
      else pass_cnt++;
    end
  endtask

  task automatic test_start_in_fill();
    clear_obs();
    drive_frame(1'b1, 1'b0, 1'b1, 0);
    wait_done();
    total++;
    if (words.size() !== 8) $display("FAIL fillstart_count: got %0d words, required 8", words.size());
    else pass_cnt++;
    for (int k = 0; k < 8 && k < words.size(); k++) begin
      total++;
      if (words[k] !== exp_word(k))
        $display("FAIL fillstart_word%0d: got %h, required %h", k, words[k], exp_word(k));
      else pass_cnt++;
    end
    total++;
    if (done_cnt !== 1 || busy !== 1'b0)
      $display("FAIL fillstart_done: pulses %0d busy %b, required 1/0", done_cnt, busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_toggle();
    test_reset_mid_stream();
    test_start_in_fill();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
